// File: rtl/bus_arb_mux.sv
// -----------------------------------------------------------------------------
// bus_arb_mux
//   Round-robin arbiter feeding a single-entry registered output bus.
//   Each cycle the output slot is free (empty, or being consumed) and some
//   source is requesting, the next requester at or after the rotating pointer
//   is granted and its word is captured into the output register.
//
// Parameters
//   W  bus data width in bits (1..32)
//   N  number of sources (2..16)
//
// Ports
//   Clock      in   system clock, rising edge
//   Resetn     in   asynchronous active-low reset
//   req        in   [N]     per-source request
//   din        in   [N*W]   source data, source i at [i*W +: W]
//   grant      out  [N]     combinational one-hot grant (0 when nothing loads)
//   bus_ready  in   sink accepts bus_data this cycle
//   bus_valid  out  bus_data holds an unconsumed word
//   bus_data   out  [W]     registered bus word
//   bus_src    out  [clog2(N)] source index of bus_data
//
// Configuration
//   BUS_HOLD_EN  defined: the last word and source stay visible after it is
//                consumed without a reload. Undefined: data/src clear to 0
//                whenever bus_valid drops.
// -----------------------------------------------------------------------------
module bus_arb_mux #(
    parameter int W = 9,
    parameter int N = 10,
    localparam int SW = $clog2(N)
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic [N-1:0]     req,
    input  logic [N*W-1:0]   din,
    output logic [N-1:0]     grant,
    input  logic             bus_ready,
    output logic             bus_valid,
    output logic [W-1:0]     bus_data,
    output logic [SW-1:0]    bus_src
);

    logic [SW-1:0] ptr_r;
    logic          valid_r;
    logic [W-1:0]  data_r;
    logic [SW-1:0] src_r;

    logic          slot_free_s;
    logic          load_s;
    logic          found_s;
    logic [SW-1:0] winner_s;
    logic [SW-1:0] ptr_next_s;

    // Output slot can take a new word when empty or being drained this cycle;
    // grant is also gated by reset so nothing is handed out while held in reset.
    always_comb begin
        slot_free_s = !valid_r || bus_ready;
        load_s      = slot_free_s && (req != {N{1'b0}}) && Resetn;
    end

    // Round-robin search: first requester at ptr, ptr+1, ... wrapping to 0.
    always_comb begin
        int idx_v;
        found_s  = 1'b0;
        winner_s = {SW{1'b0}};
        idx_v    = 0;
        for (int j = 0; j < N; j++) begin
            idx_v = int'(ptr_r) + j;
            if (idx_v >= N) begin
                idx_v = idx_v - N;
            end else begin
                idx_v = idx_v;
            end
            if (!found_s && req[idx_v]) begin
                found_s  = 1'b1;
                winner_s = SW'(idx_v);
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Pointer moves to the source after the winner, wrapping N-1 back to 0.
    always_comb begin
        if (winner_s == SW'(N - 1)) begin
            ptr_next_s = {SW{1'b0}};
        end else begin
            ptr_next_s = winner_s + {{(SW-1){1'b0}}, 1'b1};
        end
    end

    // One-hot grant to the winner only on a cycle that actually loads.
    always_comb begin
        if (load_s) begin
            grant = {{(N-1){1'b0}}, 1'b1} << winner_s;
        end else begin
            grant = {N{1'b0}};
        end
    end

    // Output register and arbitration pointer.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            ptr_r   <= {SW{1'b0}};
            valid_r <= 1'b0;
            data_r  <= {W{1'b0}};
            src_r   <= {SW{1'b0}};
        end else if (load_s) begin
            // Load also covers consume-and-replace in one edge (no bubble).
            ptr_r   <= ptr_next_s;
            valid_r <= 1'b1;
            data_r  <= din[int'(winner_s)*W +: W];
            src_r   <= winner_s;
        end else if (valid_r && bus_ready) begin
            valid_r <= 1'b0;
`ifdef BUS_HOLD_EN
            data_r  <= data_r;
            src_r   <= src_r;
`else
            data_r  <= {W{1'b0}};
            src_r   <= {SW{1'b0}};
`endif
        end else begin
            // Idle or backpressured: everything holds.
            ptr_r   <= ptr_r;
            valid_r <= valid_r;
            data_r  <= data_r;
            src_r   <= src_r;
        end
    end

    assign bus_valid = valid_r;
    assign bus_data  = data_r;
    assign bus_src   = src_r;

endmodule

// File: tb/tb_bus_arb_mux.sv
module tb_bus_arb_mux;

    localparam int N  = 10;
    localparam int W  = 9;
    localparam int SW = $clog2(N);

    typedef struct packed {
        logic [SW-1:0] src;
        logic [W-1:0]  data;
    } item_t;

    logic            Clock;
    logic            Resetn;
    logic [N-1:0]    req;
    logic [N*W-1:0]  din;
    logic [N-1:0]    grant;
    logic            bus_ready;
    logic            bus_valid;
    logic [W-1:0]    bus_data;
    logic [SW-1:0]   bus_src;

    bus_arb_mux #(.W(W), .N(N)) dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .req       (req),
        .din       (din),
        .grant     (grant),
        .bus_ready (bus_ready),
        .bus_valid (bus_valid),
        .bus_data  (bus_data),
        .bus_src   (bus_src)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Scoreboard and reference state
    item_t   sb[$];
    int      m_ptr   = 0;
    bit      m_valid = 1'b0;
    item_t   m_last  = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_word(input int i, input logic [W-1:0] w);
        din[i*W +: W] = w;
    endtask

    task automatic rand_din();
        for (int i = 0; i < N; i++) set_word(i, W'($urandom));
    endtask

    // Called at a negedge with inputs already driven; checks and advances one cycle.
    task automatic step();
        logic [N-1:0] eg;
        item_t        it;
        int           w;
        bit           ld;
        #1;
        chk("valid", {31'd0, bus_valid}, {31'd0, m_valid});
        if (!m_valid) begin
`ifdef BUS_HOLD_EN
            chk("idle_data", {23'd0, bus_data}, {23'd0, m_last.data});
            chk("idle_src", {28'd0, bus_src}, {28'd0, m_last.src});
`else
            chk("idle_data", {23'd0, bus_data}, 32'd0);
            chk("idle_src", {28'd0, bus_src}, 32'd0);
`endif
        end
        if (m_valid && bus_ready) begin
            if (sb.size() == 0) begin
                chk("sb_empty", 32'd1, 32'd0);
            end else begin
                it = sb.pop_front();
                chk("data", {23'd0, bus_data}, {23'd0, it.data});
                chk("src", {28'd0, bus_src}, {28'd0, it.src});
                m_last = it;
            end
        end
        ld = (!m_valid || bus_ready) && (req != '0);
        eg = '0;
        if (ld) begin
            w = m_ptr;
            while (!req[w]) w = (w + 1) % N;
            eg[w] = 1'b1;
            it.src  = SW'(w);
            it.data = din[w*W +: W];
            sb.push_back(it);
            m_ptr = (w + 1) % N;
            m_valid = 1'b1;
        end else if (m_valid && bus_ready) begin
            m_valid = 1'b0;
        end
        chk("grant", {22'd0, grant}, {22'd0, eg});
        @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic reset_checks();
        #1;
        chk("rst_valid", {31'd0, bus_valid}, 32'd0);
        chk("rst_data", {23'd0, bus_data}, 32'd0);
        chk("rst_src", {28'd0, bus_src}, 32'd0);
        chk("rst_grant", {22'd0, grant}, 32'd0);
        sb.delete();
        m_ptr = 0; m_valid = 1'b0; m_last = '0;
    endtask

    initial begin
        Resetn = 1'b0; req = '0; din = '0; bus_ready = 1'b1;
        req = 10'b0000010011;  // requests during reset must not be granted
        reset_checks();
        @(negedge Clock); @(negedge Clock);
        req = '0;
        Resetn = 1'b1;

        // Idle after reset
        for (int i = 0; i < 5; i++) step();

        // Round-robin 0,1,4,0,1,4
        req = 10'b0000010011;
        for (int i = 0; i < 6; i++) begin
            rand_din();
            if (i == 0) begin
                #1 chk("rr_first", {22'd0, grant}, 32'h001);
            end
            step();
        end
        req = '0;
        step();

        // Backpressure: source 3 word 1A5 held while source 7 waits
        req = 10'b0000001000; set_word(3, 9'h1A5);
        step();
        bus_ready = 1'b0; req = 10'b0010000000; rand_din();
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("bp_data", {23'd0, bus_data}, 32'h1A5);
            chk("bp_src", {28'd0, bus_src}, 32'd3);
            step();
        end
        bus_ready = 1'b1;
        #1 chk("bp_release_grant", {22'd0, grant}, 32'h080);
        step();
        req = '0;
        #1 chk("bp_src7", {28'd0, bus_src}, 32'd7);
        step();

        // Wrap: grant 8, then 9, then 2
        req = 10'b0100000000; rand_din(); step();
        req = 10'b1000000100; rand_din();
        #1 chk("wrap_g9", {22'd0, grant}, 32'h200);
        step();
        #1 chk("wrap_g2", {22'd0, grant}, 32'h004);
        step();
        req = '0; step();

        // Reset mid-transfer
        req = 10'b0000100000; rand_din(); step();
        req = '0; bus_ready = 1'b0;
        Resetn = 1'b0;
        reset_checks();
        @(posedge Clock); @(negedge Clock);
        Resetn = 1'b1; bus_ready = 1'b1;
        req = 10'b1000000100;
        #1 chk("post_rst_grant", {22'd0, grant}, 32'h004);
        step();
        req = '0; step();

        // Hold/clear after consume without reload
        req = 10'b0000100000; set_word(5, 9'h0F0); step();
        req = '0; step();
        #1;
`ifdef BUS_HOLD_EN
        chk("cfg_data", {23'd0, bus_data}, 32'h0F0);
`else
        chk("cfg_data", {23'd0, bus_data}, 32'd0);
`endif
        step();

        // Random traffic with backpressure
        for (int i = 0; i < 300; i++) begin
            req = N'($urandom);
            if ($urandom_range(0, 3) == 0) req = '0;
            bus_ready = ($urandom_range(0, 3) != 0);
            rand_din();
            step();
        end
        bus_ready = 1'b1; req = '0;
        step(); step();
        chk("sb_drained", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bus_arb_mux.md
BUS_ARB_MUX -- requirements
Module: bus_arb_mux

Interface
REQ-001 The block SHALL have parameter W, default 9, meaning bus data width in bits (legal 1..32).
REQ-002 The block SHALL have parameter N, default 10, meaning number of sources (legal 2..16).
REQ-003 The block SHALL have port Clock  input  1  system clock; all state updates on the rising edge.
REQ-004 The block SHALL have port Resetn  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port req  input  N  per-source request; bit i means source i has data.
REQ-006 The block SHALL have port din  input  N*W  source data, flat; source i occupies bits [i*W +: W].
REQ-007 The block SHALL have port grant  output  N  combinational one-hot grant, or all-zero when nothing is granted.
REQ-008 The block SHALL have port bus_ready  input  1  sink accepts bus_data this cycle.
REQ-009 The block SHALL have port bus_valid  output  1  bus_data holds an unconsumed word.
REQ-010 The block SHALL have port bus_data  output  W  registered bus word.
REQ-011 The block SHALL have port bus_src  output  clog2(N)  index of the source that supplied bus_data.

Function
REQ-012 The output stage SHALL be a single-entry register; slot_free = !bus_valid | bus_ready.
REQ-013 The load condition SHALL be load = slot_free & (req != 0).
REQ-014 Arbitration SHALL be round-robin from internal pointer ptr (width clog2(N)): the winner is the first i in ptr, ptr+1, ..., N-1, 0, ..., ptr-1 with req[i]=1.
REQ-015 When load is true, grant SHALL equal one-hot(winner); otherwise grant SHALL be 0.
REQ-016 At a rising edge with load: bus_data <= din[winner], bus_src <= winner, bus_valid <= 1, and ptr <= winner+1, wrapping N-1 -> 0.
REQ-017 At a rising edge with bus_valid & bus_ready & !load: bus_valid <= 0, and ptr SHALL be unchanged.
REQ-018 On bus_valid & !bus_ready (backpressure): bus_data, bus_src, bus_valid and ptr SHALL hold, and grant SHALL be 0.
REQ-019 On simultaneous consume and load: replace the word in the same edge with no bubble; sustained throughput SHALL be 1 word/cycle.
REQ-020 Latency SHALL be 1 cycle: data captured with grant at edge k appears on bus_data after edge k.
REQ-021 A source SHALL treat grant[i]=1 at a rising edge as consumption of its current din; a source holding req continuously SHALL be re-served only after every other requesting source has been served once (fairness bound N-1 grants).
REQ-022 With req=0 and no pending word, the block SHALL be idle, bus_valid SHALL be 0, and ptr SHALL be unchanged.
REQ-023 grant SHALL never have more than one bit set; bus_src SHALL never exceed N-1.

Reset
REQ-024 While Resetn=0, asynchronously: bus_valid=0, bus_data=0, bus_src=0, ptr=0, grant=0.
REQ-025 Assertion of Resetn mid-transfer SHALL discard the pending word with no grant issued; after release, the first grant SHALL go to the lowest requesting index.

Configuration
REQ-026 Macro BUS_HOLD_EN defined: after consume without reload, bus_data and bus_src SHALL keep the last word (bus_valid=0).
REQ-027 Macro BUS_HOLD_EN undefined: whenever bus_valid=0, bus_data and bus_src SHALL read 0 (register cleared on consume-without-reload).

Verification
REQ-028 Reset/idle: Resetn=0 then 1, req=0 for 5 cycles -> bus_valid=0, grant=0, bus_data=0 throughout.
REQ-029 Round-robin: N=10, req=10'b0000010011 held, bus_ready=1 -> grants to sources 0,1,4,0,1,4 on consecutive cycles; bus_data follows with 1-cycle lag.
REQ-030 Backpressure: source 3 word 9'h1A5 loaded, bus_ready=0 for 4 cycles with req[7]=1 -> bus_data=9'h1A5, bus_src=3 held, grant=0; bus_ready=1 -> grant[7] in that cycle, bus_src=7 next cycle with no bubble.
REQ-031 Wrap: ptr=9 after grant to source 8, req = bits 9 and 2 -> grant 9, then 2 (ptr wraps 9 -> 0).
REQ-032 Reset mid-operation: bus_valid=1, Resetn pulsed low between edges -> outputs 0 immediately; after release, req=10'b1000000100 -> first grant to source 2.
REQ-033 Config: consume source 5 word 9'h0F0 with req=0 afterwards -> bus_valid=0; bus_data=9'h0F0 with BUS_HOLD_EN, bus_data=0 without.
